// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its helpers.
package dmem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned BE_W       = DATA_W_DEF / 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a requester and the data-memory responder.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_wr;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_wr
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_wr
    );
endinterface

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take the new word, others keep the old one.
module dmem_byte_merge
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   old_word_i,
    input  logic [DATA_W-1:0]   new_word_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);
    localparam int LANES = int'(DATA_W / 8);

    always_comb begin
        merged_o = old_word_i;
        for (int i = 0; i < LANES; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_word_i[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accept, wait WAIT_CYCLES, byte-enabled access, respond.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus,
    output logic [15:0]        acc_count
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_wr_q, rsp_wr_d;
    logic [15:0]           acc_q, acc_d;
    logic                  mem_we;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     old_word;
    logic [DATA_W-1:0]     merged;
    logic [DATA_W-1:0]     mem_q [DEPTH];

    assign old_word = mem_q[addr_q];

    dmem_byte_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_word_i (old_word),
        .new_word_i (wdata_q),
        .be_i       (be_q),
        .merged_o   (merged)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_wr_d    = rsp_wr_q;
        acc_d       = acc_q;
        mem_we      = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = WAIT_INIT;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // A store with be=0 still writes back the unchanged word.
                    mem_we      = wr_q;
                    rsp_rdata_d = wr_q ? merged : old_word;
                    rsp_wr_d    = wr_q;
                    state_d     = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    acc_d   = acc_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_rdata_q <= '0;
            rsp_wr_q    <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_wr_q    <= rsp_wr_d;
            acc_q       <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= merged;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_wr    = rsp_wr_q;
    assign acc_count     = acc_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance (a) and a WAIT_CYCLES=0 instance (b).
module tb_dmem_responder;
    import dmem_pkg::*;

    logic            clk;
    logic            reset;
    logic            req_wr;
    logic [4:0]      req_addr;
    logic [31:0]     req_wdata;
    logic [BE_W-1:0] req_be;
    logic            valid_a, valid_b;
    logic            ready_a, ready_b;
    logic [15:0]     acc_a, acc_b;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_responder_if #(.ADDR_W(5), .DATA_W(32)) bus_a ();
    dmem_responder_if #(.ADDR_W(5), .DATA_W(32)) bus_b ();

    assign bus_a.req_valid = valid_a;
    assign bus_a.req_wr    = req_wr;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_a.req_be    = req_be;
    assign bus_a.rsp_ready = ready_a;
    assign bus_b.req_valid = valid_b;
    assign bus_b.req_wr    = req_wr;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_wdata = req_wdata;
    assign bus_b.req_be    = req_be;
    assign bus_b.rsp_ready = ready_b;

    dmem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_a),
        .acc_count (acc_a)
    );

    dmem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_b),
        .acc_count (acc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic get_rv(input bit sel);
        return sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    endfunction

    function automatic logic [15:0] get_acc(input bit sel);
        return sel ? acc_b : acc_a;
    endfunction

    // Called one cycle after acceptance; lat counts cycles from acceptance to rsp_valid.
    task automatic wait_rsp(input bit sel, output int lat, output logic [31:0] rd,
                            output logic rw);
        lat = 1;
        while (!get_rv(sel) && lat < 40) begin
            tick();
            lat++;
        end
        if (!get_rv(sel)) check("rsp_timeout", 32'd0, 32'd1);
        rd = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
        rw = sel ? bus_b.rsp_wr : bus_a.rsp_wr;
        if (sel) ready_b = 1'b1; else ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    task automatic txn(input bit sel, input logic wr, input logic [4:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic rw, output int lat);
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
        wait_rsp(sel, lat, rd, rw);
    endtask

    initial begin : main
        logic [31:0] rd;
        logic        rw;
        int          lat;
        bit          seen;

        reset = 1'b1; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        valid_a = 1'b0; valid_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
        check("rst_rsp_wr", 32'(bus_a.rsp_wr), 32'd0);
        check("rst_acc", 32'(acc_a), 32'd0);

        // Load from a freshly cleared word.
        txn(1'b0, 1'b0, 5'd5, 32'hFFFF_FFFF, 4'hF, rd, rw, lat);
        check("load5_lat", 32'(lat), 32'd4);
        check("load5_rdata", rd, 32'h0000_0000);
        check("load5_wr", 32'(rw), 32'd0);
        check("load5_acc", 32'(acc_a), 32'd1);

        txn(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 4'hF, rd, rw, lat);
        check("st3_rdata", rd, 32'hDEAD_BEEF);
        check("st3_wr", 32'(rw), 32'd1);
        txn(1'b0, 1'b0, 5'd3, 32'h0, 4'h0, rd, rw, lat);
        check("ld3_rdata", rd, 32'hDEAD_BEEF);

        txn(1'b0, 1'b1, 5'd3, 32'h0000_5500, 4'b0010, rd, rw, lat);
        check("pst3_rdata", rd, 32'hDEAD_55EF);
        txn(1'b0, 1'b0, 5'd3, 32'h0, 4'h0, rd, rw, lat);
        check("pld3_rdata", rd, 32'hDEAD_55EF);
        txn(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'b0000, rd, rw, lat);
        check("be0_rdata", rd, 32'hDEAD_55EF);
        check("be0_wr", 32'(rw), 32'd1);
        txn(1'b0, 1'b0, 5'd3, 32'h0, 4'h0, rd, rw, lat);
        check("be0_ld3", rd, 32'hDEAD_55EF);
        check("acc7", 32'(acc_a), 32'd7);

        // Backpressure: hold the load response while a new request is pending.
        req_wr = 1'b0; req_addr = 5'd3; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        lat = 1;
        while (!bus_a.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd4);
        req_wr = 1'b1; req_addr = 5'd9; req_wdata = 32'h1111_1111; req_be = 4'hF;
        valid_a = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
            check("bp_rsp_rdata", bus_a.rsp_rdata, 32'hDEAD_55EF);
            check("bp_rsp_wr", 32'(bus_a.rsp_wr), 32'd0);
            check("bp_req_ready", 32'(bus_a.req_ready), 32'd0);
            tick();
        end
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("bp_hs_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("bp_hs_ready", 32'(bus_a.req_ready), 32'd1);
        check("bp_hs_acc", 32'(acc_a), 32'd8);
        tick();
        valid_a = 1'b0;
        check("bp_acc_req", 32'(bus_a.req_ready), 32'd0);
        wait_rsp(1'b0, lat, rd, rw);
        check("bp_st9_lat", 32'(lat), 32'd4);
        check("bp_st9_rdata", rd, 32'h1111_1111);
        check("bp_st9_wr", 32'(rw), 32'd1);
        txn(1'b0, 1'b0, 5'd9, 32'h0, 4'h0, rd, rw, lat);
        check("ld9_rdata", rd, 32'h1111_1111);

        // rsp_ready while idle must not count a transaction.
        ready_a = 1'b1;
        tick();
        tick();
        ready_a = 1'b0;
        check("idle_ready_acc", 32'(acc_a), 32'd10);

        // Zero-wait instance; top and bottom addresses are distinct words.
        txn(1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5, 4'hF, rd, rw, lat);
        check("b_st31_lat", 32'(lat), 32'd2);
        txn(1'b1, 1'b1, 5'd0, 32'h5A5A_5A5A, 4'hF, rd, rw, lat);
        txn(1'b1, 1'b0, 5'd31, 32'h0, 4'h0, rd, rw, lat);
        check("b_ld31_lat", 32'(lat), 32'd2);
        check("b_ld31_rdata", rd, 32'hA5A5_A5A5);
        check("b_acc3", 32'(acc_b), 32'd3);
        txn(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, rd, rw, lat);
        check("b_ld0_rdata", rd, 32'h5A5A_5A5A);

        // Reset during WAIT aborts the store and produces no response.
        req_wr = 1'b1; req_addr = 5'd7; req_wdata = 32'h1234_5678; req_be = 4'hF;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rw_req_ready", 32'(bus_a.req_ready), 32'd1);
        check("rw_acc", 32'(acc_a), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus_a.rsp_valid) seen = 1'b1;
            tick();
        end
        check("rw_no_rsp", 32'(seen), 32'd0);
        txn(1'b0, 1'b0, 5'd7, 32'h0, 4'h0, rd, rw, lat);
        check("rw_ld7_rdata", rd, 32'h0000_0000);
        check("rw_acc1", 32'(acc_a), 32'd1);
        txn(1'b0, 1'b0, 5'd3, 32'h0, 4'h0, rd, rw, lat);
        check("rw_ld3_cleared", rd, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
